// File: rtl/hit_logic.sv
// -----------------------------------------------------------------------------
// hit_logic -- scoring front end for the Whac-A-Mole game.
//
// Compares player switch toggles (either direction) against the live mole
// pattern. Tracks which moles of the current round are already whacked, drives
// the hole LEDs, and emits one-cycle hit/miss pulses to the scoring FSM.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous, active-high reset
//   mole_positions      [NUM_HOLES] bit i = mole up in hole i (synchronous)
//   switches            [NUM_HOLES] player toggle switches
//   game_in_progress    1 = scoring enabled
//   LEDs                [NUM_HOLES] live (not yet hit) moles, registered
//   miss                pulse: a toggle hit no live mole
//   non_full_clear_hit  pulse: a live mole hit, other live moles remain
//   full_clear_hit      pulse: the last live mole(s) of the round hit
//
// Build option:
//   HIT_LOGIC_SYNC_EN   when defined, a 2-flop synchronizer per switch bit
//                       precedes edge detection (switch-to-pulse latency 3
//                       clocks instead of 1).
// -----------------------------------------------------------------------------
module hit_logic #(
   parameter int NUM_HOLES = 18
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_HOLES-1:0] mole_positions,
   input  logic [NUM_HOLES-1:0] switches,
   input  logic                 game_in_progress,
   output logic [NUM_HOLES-1:0] LEDs,
   output logic                 miss,
   output logic                 non_full_clear_hit,
   output logic                 full_clear_hit
);

   logic [NUM_HOLES-1:0] sw_s;
   logic [NUM_HOLES-1:0] sw_prev;
   logic [NUM_HOLES-1:0] mole_prev;
   logic [NUM_HOLES-1:0] hit_mask;
   logic                 primed;

`ifdef HIT_LOGIC_SYNC_EN
   logic [NUM_HOLES-1:0] sync_meta;
   logic [NUM_HOLES-1:0] sync_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= '0;
         sync_out  <= '0;
      end else begin
         sync_meta <= switches;
         sync_out  <= sync_meta;
      end
   end

   assign sw_s = sync_out;
`else
   assign sw_s = switches;
`endif

   logic                 new_round;
   logic [NUM_HOLES-1:0] hit_mask_eff;
   logic [NUM_HOLES-1:0] live;
   logic [NUM_HOLES-1:0] toggled;
   logic                 scoring;
   logic [NUM_HOLES-1:0] valid;
   logic [NUM_HOLES-1:0] wrong;
   logic                 clear_all;

   always_comb begin
      // A pattern change starts a fresh round: forget earlier hits in the
      // same evaluation so a toggle on this cycle scores against the new moles.
      new_round    = (mole_positions != mole_prev);
      hit_mask_eff = new_round ? '0 : hit_mask;
      live         = mole_positions & ~hit_mask_eff;
      toggled      = sw_s ^ sw_prev;
      // The first cycle after reset only primes sw_prev.
      scoring      = game_in_progress & primed;
      valid        = scoring ? (toggled & live)  : '0;
      wrong        = scoring ? (toggled & ~live) : '0;
      // An empty pattern can never be "cleared"; it only produces misses.
      clear_all    = ((live & ~valid) == '0) && (mole_positions != '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         primed             <= 1'b0;
         sw_prev            <= '0;
         mole_prev          <= '0;
         hit_mask           <= '0;
         LEDs               <= '0;
         miss               <= 1'b0;
         non_full_clear_hit <= 1'b0;
         full_clear_hit     <= 1'b0;
      end else begin
         primed    <= 1'b1;
         // Tracks even while idle so toggles made between games never count.
         sw_prev   <= sw_s;
         mole_prev <= mole_positions;
         if (game_in_progress) begin
            hit_mask           <= hit_mask_eff | valid;
            LEDs               <= mole_positions & ~(hit_mask_eff | valid);
            miss               <= |wrong;
            full_clear_hit     <= (|valid) & clear_all;
            non_full_clear_hit <= (|valid) & ~clear_all;
         end else begin
            hit_mask           <= '0;
            LEDs               <= '0;
            miss               <= 1'b0;
            full_clear_hit     <= 1'b0;
            non_full_clear_hit <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hit_logic.sv
// -----------------------------------------------------------------------------
// tb_hit_logic -- directed self-checking bench for hit_logic.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_hit_logic;

   localparam int N = 18;
`ifdef HIT_LOGIC_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] mole_positions;
   logic [N-1:0] switches;
   logic         game_in_progress;
   logic [N-1:0] LEDs;
   logic         miss;
   logic         non_full_clear_hit;
   logic         full_clear_hit;

   int vec_count = 0;
   int err_count = 0;

   hit_logic #(.NUM_HOLES(N)) dut (
      .clk                (clk),
      .reset              (reset),
      .mole_positions     (mole_positions),
      .switches           (switches),
      .game_in_progress   (game_in_progress),
      .LEDs               (LEDs),
      .miss               (miss),
      .non_full_clear_hit (non_full_clear_hit),
      .full_clear_hit     (full_clear_hit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [N-1:0] leds_exp,
                             input logic m_exp, input logic nfc_exp, input logic fc_exp);
      $display("[%0t] %s: LEDs=%h miss=%b nfc=%b fc=%b", $time, tag, LEDs, miss,
               non_full_clear_hit, full_clear_hit);
      check({tag, ".LEDs"}, 32'(LEDs), 32'(leds_exp));
      check({tag, ".miss"}, 32'(miss), 32'(m_exp));
      check({tag, ".nfc"},  32'(non_full_clear_hit), 32'(nfc_exp));
      check({tag, ".fc"},   32'(full_clear_hit), 32'(fc_exp));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic toggle(input logic [N-1:0] bits);
      switches = switches ^ bits;
   endtask

   initial begin
      reset            = 1'b1;
      game_in_progress = 1'b1;
      mole_positions   = 18'b101010 << 12;
      switches         = '0;
      tick(2);
      expect_out("reset_state", 18'h0, 0, 0, 0);
      reset = 1'b0;
      tick(1);
      expect_out("first_pattern", 18'h2A000, 0, 0, 0);

      toggle(18'h1 << 17); tick(LAT);
      expect_out("hit_sw17", 18'h0A000, 0, 1, 0);
      tick(1);
      expect_out("pulse_one_cycle", 18'h0A000, 0, 0, 0);
      toggle(18'h1 << 15); tick(LAT);
      expect_out("hit_sw15", 18'h02000, 0, 1, 0);
      toggle(18'h1 << 13); tick(LAT);
      expect_out("full_clear_sw13", 18'h0, 0, 0, 1);
      tick(1);
      expect_out("full_clear_drop", 18'h0, 0, 0, 0);
      toggle(18'h1 << 16); tick(LAT);
      expect_out("miss_empty", 18'h0, 1, 0, 0);
      toggle(18'h1 << 17); tick(LAT);
      expect_out("miss_already_hit", 18'h0, 1, 0, 0);
      tick(1);
      expect_out("static_switches", 18'h0, 0, 0, 0);

      mole_positions = '0; tick(1);
      expect_out("empty_round", 18'h0, 0, 0, 0);
      toggle(18'h1 << 14); tick(LAT);
      expect_out("empty_round_miss", 18'h0, 1, 0, 0);

      mole_positions = 18'b111 << 15; tick(1);
      expect_out("new_round", 18'h38000, 0, 0, 0);
      toggle(18'h1 << 17); tick(LAT);
      expect_out("r2_sw17", 18'h18000, 0, 1, 0);
      toggle(18'h1 << 16); tick(LAT);
      expect_out("r2_sw16", 18'h08000, 0, 1, 0);
      toggle(18'h1 << 15); tick(LAT);
      expect_out("r2_sw15_clear", 18'h0, 0, 0, 1);

      mole_positions = 18'h00007; tick(1);
      expect_out("r3_pattern", 18'h00007, 0, 0, 0);
      toggle(18'h00021); tick(LAT);
      expect_out("hit_and_miss", 18'h00006, 1, 1, 0);
      toggle(18'h00006); tick(LAT);
      expect_out("multi_clear", 18'h0, 0, 0, 1);

      // Toggle and pattern change on the same cycle: scored on the new pattern.
      mole_positions = 18'h00300;
      toggle(18'h00100); tick(LAT);
      expect_out("same_cycle_round", 18'h00200, 0, 1, 0);

      game_in_progress = 1'b0;
      toggle(18'h00208); tick(LAT);
      expect_out("idle_toggle", 18'h0, 0, 0, 0);
      tick(2);
      expect_out("idle_quiet", 18'h0, 0, 0, 0);
      game_in_progress = 1'b1;
      mole_positions   = 18'h1C000; tick(1);
      expect_out("reenable", 18'h1C000, 0, 0, 0);
      tick(2);
      expect_out("reenable_quiet", 18'h1C000, 0, 0, 0);

      toggle(18'h1 << 14); tick(LAT);
      expect_out("pre_reset_hit", 18'h18000, 0, 1, 0);
      #3 reset = 1'b1;
      #1;
      expect_out("async_reset", 18'h0, 0, 0, 0);
      toggle(18'h1 << 16);
      tick(2);
      reset = 1'b0;
`ifndef HIT_LOGIC_SYNC_EN
      // sw_prev was cleared while switches are non-zero: only priming occurs.
      tick(1);
      expect_out("prime_cycle", 18'h1C000, 0, 0, 0);
      tick(1);
      expect_out("after_prime", 18'h1C000, 0, 0, 0);
      toggle(18'h1 << 15); tick(LAT);
      expect_out("fresh_round_hit", 18'h14000, 0, 1, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
